// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: data-cache port of the EX/MEM pipeline stage.
// The stage drives the request (master). The data cache answers with
// dhit and dmemload (slave).
interface ex_mem_stage_if;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;

  modport master (
    input  dhit,
    input  dmemload,
    output dmemREN,
    output dmemWEN,
    output dmemaddr,
    output dmemstore
  );

  modport slave (
    output dhit,
    output dmemload,
    input  dmemREN,
    input  dmemWEN,
    input  dmemaddr,
    input  dmemstore
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with a data-cache access FSM.
// A captured load or store raises mem_stall until the cache answers with dhit.
// A flush that arrives during an access is remembered and applied once the
// access completes. Once halt is captured, the stage stops advancing.
// Optional macro EX_MEM_FWD_EN enables the forwarding outputs. In the
// default build those outputs are tied to zero.
module ex_mem_stage (
  input  logic                  CLK,
  input  logic                  nRST,
  // EX side
  input  logic [31:0]           aluout_i,
  input  logic [31:0]           rdat2_i,
  input  logic [4:0]            wsel_i,
  input  logic [31:0]           pc4_i,
  input  logic                  RegWr_i,
  input  logic                  dREN_i,
  input  logic                  dWEN_i,
  input  logic                  MemToReg_i,
  input  logic                  halt_i,
  // pipeline control
  input  logic                  en,
  input  logic                  flush,
  // data cache
  ex_mem_stage_if.master        dmem,
  // WB side
  output logic [31:0]           aluout_o,
  output logic [31:0]           dload_o,
  output logic [4:0]            wsel_o,
  output logic [31:0]           pc4_o,
  output logic                  RegWr_o,
  output logic                  MemToReg_o,
  output logic                  halt_o,
  output logic                  mem_stall,
  // forwarding
  output logic                  fwd_valid,
  output logic [4:0]            fwd_wsel,
  output logic [31:0]           fwd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] aluout;
    logic [31:0] rdat2;
    logic [4:0]  wsel;
    logic [31:0] pc4;
    logic        regwr;
    logic        dren;
    logic        dwen;
    logic        memtoreg;
    logic        halt;
  } stage_t;

  stage_t      stage_q;
  logic [31:0] dload_q;
  state_t      state_q;
  logic        pend_flush_q;

  logic        in_req_s;
  logic        rd_req_s;
  logic        wr_req_s;

  // A store takes precedence when both enables are set.
  assign in_req_s = (state_q == REQ);
  assign wr_req_s = in_req_s & stage_q.dwen;
  assign rd_req_s = in_req_s & stage_q.dren & ~stage_q.dwen;

  // FSM and pipeline register. An access in flight blocks en and flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stage_q      <= '0;
      dload_q      <= 32'd0;
      state_q      <= IDLE;
      pend_flush_q <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          if (dmem.dhit) begin
            if (pend_flush_q || flush) begin
              // The access has finished, so the deferred flush now applies.
              stage_q      <= '0;
              dload_q      <= 32'd0;
              pend_flush_q <= 1'b0;
              state_q      <= IDLE;
            end else begin
              if (rd_req_s) begin
                dload_q <= dmem.dmemload;
              end else begin
                dload_q <= dload_q;
              end
              state_q <= DONE;
            end
          end else if (flush) begin
            pend_flush_q <= 1'b1;
          end else begin
            state_q <= REQ;
          end
        end
        IDLE, DONE: begin
          if (flush) begin
            stage_q      <= '0;
            dload_q      <= 32'd0;
            pend_flush_q <= 1'b0;
            state_q      <= IDLE;
          end else if (en && !stage_q.halt) begin
            stage_q <= '{aluout:   aluout_i,
                         rdat2:    rdat2_i,
                         wsel:     wsel_i,
                         pc4:      pc4_i,
                         regwr:    RegWr_i,
                         dren:     dREN_i,
                         dwen:     dWEN_i,
                         memtoreg: MemToReg_i,
                         halt:     halt_i};
            dload_q <= 32'd0;
            state_q <= (dREN_i || dWEN_i) ? REQ : IDLE;
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          stage_q      <= '0;
          dload_q      <= 32'd0;
          pend_flush_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // Cache request is decoded from the registered state only. A reset drops it at once.
  assign dmem.dmemREN   = rd_req_s;
  assign dmem.dmemWEN   = wr_req_s;
  assign dmem.dmemaddr  = {stage_q.aluout[31:2], 2'b00};
  assign dmem.dmemstore = stage_q.rdat2;
  assign mem_stall      = in_req_s;

  assign aluout_o   = stage_q.aluout;
  assign dload_o    = dload_q;
  assign wsel_o     = stage_q.wsel;
  assign pc4_o      = stage_q.pc4;
  assign RegWr_o    = stage_q.regwr;
  assign MemToReg_o = stage_q.memtoreg;
  assign halt_o     = stage_q.halt;

`ifdef EX_MEM_FWD_EN
  // Results are forwarded only when no access is in flight. Register 0 is never forwarded.
  assign fwd_valid = stage_q.regwr & (stage_q.wsel != 5'd0) & ~in_req_s;
  assign fwd_wsel  = stage_q.wsel;
  assign fwd_data  = stage_q.memtoreg ? dload_q : stage_q.aluout;
`else
  assign fwd_valid = 1'b0;
  assign fwd_wsel  = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: self-checking bench for ex_mem_stage.
// Runs directed scenarios and then randomized traffic. A transaction-level
// model checks every output on every cycle.
module tb_ex_mem_stage;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] aluout_i, rdat2_i, pc4_i;
  logic [4:0]  wsel_i;
  logic        RegWr_i, dREN_i, dWEN_i, MemToReg_i, halt_i;
  logic        en, flush;
  logic [31:0] aluout_o, dload_o, pc4_o, fwd_data;
  logic [4:0]  wsel_o, fwd_wsel;
  logic        RegWr_o, MemToReg_o, halt_o, mem_stall, fwd_valid;

  ex_mem_stage_if dmem_if ();

  ex_mem_stage dut (
    .CLK(CLK), .nRST(nRST),
    .aluout_i(aluout_i), .rdat2_i(rdat2_i), .wsel_i(wsel_i), .pc4_i(pc4_i),
    .RegWr_i(RegWr_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i),
    .MemToReg_i(MemToReg_i), .halt_i(halt_i),
    .en(en), .flush(flush),
    .dmem(dmem_if),
    .aluout_o(aluout_o), .dload_o(dload_o), .wsel_o(wsel_o), .pc4_o(pc4_o),
    .RegWr_o(RegWr_o), .MemToReg_o(MemToReg_o), .halt_o(halt_o),
    .mem_stall(mem_stall),
    .fwd_valid(fwd_valid), .fwd_wsel(fwd_wsel), .fwd_data(fwd_data)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model. It tracks the held instruction, whether a cache access
  // is outstanding, and whether a flush is waiting for that access to end.
  logic [31:0] m_alu, m_rd2, m_pc4, m_dload;
  logic [4:0]  m_wsel;
  logic        m_regwr, m_dren, m_dwen, m_m2r, m_halt;
  logic        m_busy, m_pflush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_alu = 32'd0; m_rd2 = 32'd0; m_pc4 = 32'd0; m_dload = 32'd0; m_wsel = 5'd0;
    m_regwr = 1'b0; m_dren = 1'b0; m_dwen = 1'b0; m_m2r = 1'b0; m_halt = 1'b0;
    m_busy = 1'b0; m_pflush = 1'b0;
  endtask

  // Apply one clock edge to the model. This uses the inputs as they were at the edge.
  task automatic model_step();
    if (!nRST) begin
      model_clear();
    end else if (m_busy) begin
      if (flush) m_pflush = 1'b1;
      if (dmem_if.dhit) begin
        if (m_pflush) begin
          model_clear();
        end else begin
          if (m_dren && !m_dwen) m_dload = dmem_if.dmemload;
          m_busy = 1'b0;
        end
      end
    end else if (flush) begin
      model_clear();
    end else if (en && !m_halt) begin
      m_alu = aluout_i; m_rd2 = rdat2_i; m_pc4 = pc4_i; m_wsel = wsel_i;
      m_regwr = RegWr_i; m_dren = dREN_i; m_dwen = dWEN_i; m_m2r = MemToReg_i;
      m_halt = halt_i; m_dload = 32'd0;
      m_busy = dREN_i | dWEN_i;
    end
  endtask

  task automatic check_all();
    check("aluout_o", aluout_o, m_alu);
    check("dload_o", dload_o, m_dload);
    check("wsel_o", {27'd0, wsel_o}, {27'd0, m_wsel});
    check("pc4_o", pc4_o, m_pc4);
    check("RegWr_o", {31'd0, RegWr_o}, {31'd0, m_regwr});
    check("MemToReg_o", {31'd0, MemToReg_o}, {31'd0, m_m2r});
    check("halt_o", {31'd0, halt_o}, {31'd0, m_halt});
    check("mem_stall", {31'd0, mem_stall}, {31'd0, m_busy});
    check("dmemREN", {31'd0, dmem_if.dmemREN}, {31'd0, m_busy & m_dren & ~m_dwen});
    check("dmemWEN", {31'd0, dmem_if.dmemWEN}, {31'd0, m_busy & m_dwen});
    check("dmemaddr", dmem_if.dmemaddr, m_alu & 32'hFFFF_FFFC);
    check("dmemstore", dmem_if.dmemstore, m_rd2);
`ifdef EX_MEM_FWD_EN
    check("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_regwr & (m_wsel != 5'd0) & ~m_busy});
    check("fwd_wsel", {27'd0, fwd_wsel}, {27'd0, m_wsel});
    check("fwd_data", fwd_data, m_m2r ? m_dload : m_alu);
`else
    check("fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("fwd_wsel", {27'd0, fwd_wsel}, 32'd0);
    check("fwd_data", fwd_data, 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] ws,
                        input logic rw, input logic rn, input logic wn, input logic m2r,
                        input logic hl);
    aluout_i = alu; rdat2_i = rd2; wsel_i = ws; pc4_i = alu + 32'd4;
    RegWr_i = rw; dREN_i = rn; dWEN_i = wn; MemToReg_i = m2r; halt_i = hl;
  endtask

  initial begin
    nRST = 1'b0; en = 1'b0; flush = 1'b0;
    set_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_if.dhit = 1'b0; dmem_if.dmemload = 32'd0;
    model_clear();
    #1;
    check_all();
    tick(); tick();
    nRST = 1'b1;

    // ALU op
    set_ex(32'h10, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); en = 1'b1;
    tick();
    en = 1'b0;
    check("alu_aluout", aluout_o, 32'h10);
    check("alu_wsel", {27'd0, wsel_o}, 32'd5);
    check("alu_stall", {31'd0, mem_stall}, 32'd0);
    check("alu_ren", {31'd0, dmem_if.dmemREN}, 32'd0);

    // Load with three miss cycles
    set_ex(32'h103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); en = 1'b1;
    tick();
    en = 1'b0;
    check("ld_addr", dmem_if.dmemaddr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      check("ld_stall", {31'd0, mem_stall}, 32'd1);
      check("ld_ren", {31'd0, dmem_if.dmemREN}, 32'd1);
      tick();
    end
    dmem_if.dhit = 1'b1; dmem_if.dmemload = 32'hDEADBEEF;
    check("ld_stall4", {31'd0, mem_stall}, 32'd1);
    tick();
    dmem_if.dhit = 1'b0;
    check("ld_data", dload_o, 32'hDEADBEEF);
    check("ld_done_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("ld_hold", dload_o, 32'hDEADBEEF);

    // Store with a flush during the access
    set_ex(32'h200, 32'hCAFE, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); en = 1'b1;
    tick();
    en = 1'b0;
    check("st_wen", {31'd0, dmem_if.dmemWEN}, 32'd1);
    check("st_data", dmem_if.dmemstore, 32'hCAFE);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("st_wen_hold", {31'd0, dmem_if.dmemWEN}, 32'd1);
    check("st_alu_hold", aluout_o, 32'h200);
    dmem_if.dhit = 1'b1;
    tick();
    dmem_if.dhit = 1'b0;
    check("st_flushed_alu", aluout_o, 32'd0);
    check("st_flushed_store", dmem_if.dmemstore, 32'd0);
    check("st_flushed_wen", {31'd0, dmem_if.dmemWEN}, 32'd0);

    // Halt blocks later captures until a flush clears it
    set_ex(32'h20, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); en = 1'b1;
    tick();
    set_ex(32'h55, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("halt_o", {31'd0, halt_o}, 32'd1);
    check("halt_ren", {31'd0, dmem_if.dmemREN}, 32'd0);
    check("halt_alu", aluout_o, 32'h20);
    en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("halt_cleared", {31'd0, halt_o}, 32'd0);

    // Reset in the middle of an access
    set_ex(32'h300, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); en = 1'b1;
    tick();
    en = 1'b0;
    check("rst_pre_ren", {31'd0, dmem_if.dmemREN}, 32'd1);
    nRST = 1'b0;
    #1;
    model_clear();
    check("rst_ren", {31'd0, dmem_if.dmemREN}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check_all();
    tick();
    nRST = 1'b1;

    // Forwarding: a write to register 0 is never forwarded
    set_ex(32'h44, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); en = 1'b1;
    tick();
    check("fwd_r0", {31'd0, fwd_valid}, 32'd0);
    set_ex(32'h48, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
`ifdef EX_MEM_FWD_EN
    check("fwd_r9", {31'd0, fwd_valid}, 32'd1);
`else
    check("fwd_off", {31'd0, fwd_valid}, 32'd0);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      set_ex($urandom, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) < 2), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 49) == 0));
      en = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 9) == 0);
      dmem_if.dhit = ($urandom_range(0, 9) < 3);
      dmem_if.dmemload = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        nRST = 1'b0;
        #1;
        model_clear();
        check_all();
      end
      tick();
      nRST = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have ports: CLK in 1 (clock, rising edge); nRST in 1 (asynchronous, active-low reset).
REQ-002 SHALL have EX-side inputs: aluout_i 32 (ALU result/address); rdat2_i 32 (store data); wsel_i 5 (destination register); pc4_i 32; RegWr_i, dREN_i, dWEN_i, MemToReg_i, halt_i 1 each.
REQ-003 SHALL have control inputs: en 1 (advance stage); flush 1 (load bubble).
REQ-004 SHALL have cache-side signals: dhit in 1; dmemload in 32; dmemREN out 1; dmemWEN out 1; dmemaddr out 32; dmemstore out 32.
REQ-005 SHALL have WB-side outputs: aluout_o 32, dload_o 32, wsel_o 5, pc4_o 32, RegWr_o, MemToReg_o, halt_o 1 each; mem_stall out 1 (freeze upstream stages).
REQ-006 SHALL have forwarding outputs: fwd_valid out 1; fwd_wsel out 5; fwd_data out 32.

Function
REQ-007 SHALL hold a pipeline register for all *_i fields plus an FSM with states IDLE, REQ, DONE.
REQ-008 Register update priority SHALL be: mem_stall, then flush, then en, then hold.
REQ-009 While mem_stall=1, en and flush SHALL NOT change the register; flush seen in REQ SHALL set pending_flush.
REQ-010 flush with mem_stall=0 SHALL load all fields to 0 and enter IDLE.
REQ-011 en=1, flush=0, mem_stall=0, halt_o=0 SHALL capture all *_i fields on the rising edge; dload_o SHALL clear to 0.
REQ-012 After a capture, next state SHALL be REQ if dREN_i or dWEN_i was 1, else IDLE.
REQ-013 In REQ: dmemREN=dREN_o, dmemWEN=dWEN_o, dmemaddr={aluout_o[31:2],2'b00}, dmemstore=rdat2_o, mem_stall=1.
REQ-014 In IDLE and DONE: dmemREN=dmemWEN=0, mem_stall=0; dmemaddr and dmemstore SHALL still show the REQ values.
REQ-015 In REQ with dhit=1: SHALL capture dmemload into dload_o when the request is a read; state SHALL go to DONE.
REQ-016 In REQ with dhit=0: SHALL stay in REQ with no cycle limit.
REQ-017 If pending_flush=1 when dhit arrives: SHALL complete the access, then zero all fields, clear pending_flush and go to IDLE, not DONE.
REQ-018 DONE SHALL last until the next capture or flush, then follow REQ-010/REQ-012.
REQ-019 Load latency: capture edge, then at least 1 REQ cycle, then dhit edge; dload_o SHALL be valid on the cycle after dhit.
REQ-020 Once halt_o=1, SHALL ignore en and issue no further requests until reset; flush SHALL still clear halt_o.
REQ-021 dmemREN and dmemWEN SHALL never both be 1; if dREN_o=dWEN_o=1, only dmemWEN SHALL assert.

Reset
REQ-022 nRST=0 SHALL asynchronously clear all registered outputs, the FSM (to IDLE) and pending_flush.
REQ-023 Reset during REQ SHALL drop dmemREN/dmemWEN in that same cycle, with no completion.

Configuration
REQ-024 Macro EX_MEM_FWD_EN defined: fwd_valid=RegWr_o & (wsel_o!=0) & ~mem_stall; fwd_wsel=wsel_o; fwd_data=MemToReg_o ? dload_o : aluout_o (combinational).
REQ-025 Macro EX_MEM_FWD_EN undefined: fwd_valid, fwd_wsel and fwd_data SHALL be constant 0; ports remain.

Verification
REQ-026 ALU op: aluout_i=0x10, wsel_i=5, RegWr_i=1, en=1 -> next cycle aluout_o=0x10, wsel_o=5, mem_stall=0, dmemREN=0.
REQ-027 Load: dREN_i=1, aluout_i=0x103, dhit low 3 cycles then dmemload=0xDEADBEEF with dhit=1 -> dmemaddr=0x100; mem_stall=1 for 4 cycles; then dload_o=0xDEADBEEF, state DONE.
REQ-028 Store under flush: dWEN_i=1, rdat2_i=0xCAFE, flush=1 during REQ, dhit after 2 cycles -> dmemWEN held until dhit, dmemstore=0xCAFE, then all outputs 0, IDLE.
REQ-029 Halt: halt_i=1 captured, then en=1 with dREN_i=1 -> halt_o stays 1, dmemREN stays 0, register unchanged.
REQ-030 Reset mid-REQ: nRST low during REQ -> dmemREN=0 immediately, all outputs 0; with EX_MEM_FWD_EN, fwd_valid=0 during stall and after a wsel_i=0 write.
